// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: issues PC fetches, tracks in-flight requests and buffers {inst, pc} for decode.
// Optional macro FETCH_BYPASS_EN forwards a live response straight to decode when the buffer is empty.
module fetch_ctrl #(
    parameter int DEPTH = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_pc_addr,
    input  logic        i_redirect,
    input  logic        i_halt,
    output logic        o_pc_hold,
    output logic        o_mem_req,
    output logic [31:0] o_mem_addr,
    input  logic        i_mem_gnt,
    input  logic        i_mem_rvalid,
    input  logic [31:0] i_mem_rdata,
    output logic        o_inst_valid,
    output logic [31:0] o_inst,
    output logic [31:0] o_inst_pc,
    input  logic        i_dec_ready,
    output logic        o_busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_HALT
    } state_t;

    state_t state_q, state_d;

    logic [CW-1:0] out_cnt, drop_cnt, buf_cnt, live, drop_d;
    logic [AW-1:0] pc_wr, pc_rd, buf_wr, buf_rd;
    logic [31:0]   pc_mem   [DEPTH];
    logic [31:0]   inst_mem [DEPTH];
    logic [31:0]   ipc_mem  [DEPTH];

    logic          gnt_acc, resp_ok, resp_drop, resp_live;
    logic          buf_push, buf_pop, bypass;
    logic [CW:0]   credit_used;

    assign live    = out_cnt - drop_cnt;
    assign buf_pop = (buf_cnt != '0) & ~i_redirect & i_dec_ready;

    // A pop this cycle returns its credit immediately, so fetch can refill in the same cycle.
    assign credit_used = {1'b0, buf_cnt} - {{CW{1'b0}}, buf_pop} + {1'b0, live};

    assign o_mem_req  = ~i_rst & ~i_halt & (out_cnt < DEPTH_C)
                      & (i_redirect | (credit_used < {1'b0, DEPTH_C}));
    assign o_mem_addr = i_pc_addr;
    assign gnt_acc    = o_mem_req & i_mem_gnt;
    assign o_pc_hold  = ~gnt_acc;

    // With out_cnt = 0 a response has no owner and is ignored entirely.
    assign resp_ok   = i_mem_rvalid & (out_cnt != '0);
    assign resp_drop = resp_ok & (drop_cnt != '0);
    assign resp_live = resp_ok & (drop_cnt == '0) & ~i_redirect;

`ifdef FETCH_BYPASS_EN
    assign bypass = resp_live & (buf_cnt == '0) & i_dec_ready;
`else
    assign bypass = 1'b0;
`endif

    assign buf_push = resp_live & ~bypass;

    assign o_inst_valid = ((buf_cnt != '0) & ~i_redirect) | bypass;
    assign o_inst       = bypass ? i_mem_rdata   : inst_mem[buf_rd];
    assign o_inst_pc    = bypass ? pc_mem[pc_rd] : ipc_mem[buf_rd];
    assign o_busy       = (out_cnt != '0) | (buf_cnt != '0);

    // A redirect turns everything still in flight into responses to discard.
    assign drop_d = i_redirect ? (out_cnt - CW'(resp_ok)) : (drop_cnt - CW'(resp_drop));

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RUN: begin
                if (i_halt)              state_d = ST_HALT;
                else if (drop_d != '0)   state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (i_halt)              state_d = ST_HALT;
                else if (drop_d == '0)   state_d = ST_RUN;
            end
            ST_HALT: begin
                if (!i_halt)             state_d = (drop_d != '0) ? ST_DRAIN : ST_RUN;
            end
            default:                     state_d = ST_RUN;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= ST_RUN;
            out_cnt  <= '0;
            drop_cnt <= '0;
            buf_cnt  <= '0;
            pc_wr    <= '0;
            pc_rd    <= '0;
            buf_wr   <= '0;
            buf_rd   <= '0;
        end else begin
            state_q  <= state_d;
            out_cnt  <= out_cnt + CW'(gnt_acc) - CW'(resp_ok);
            drop_cnt <= drop_d;
            if (gnt_acc) pc_wr <= pc_wr + AW'(1);
            if (i_redirect) begin
                // Only a request granted in this cycle (written at the old pc_wr) survives.
                pc_rd   <= pc_wr;
                buf_rd  <= buf_wr;
                buf_cnt <= '0;
            end else begin
                if (resp_live) pc_rd  <= pc_rd + AW'(1);
                if (buf_push)  buf_wr <= buf_wr + AW'(1);
                if (buf_pop)   buf_rd <= buf_rd + AW'(1);
                buf_cnt <= buf_cnt + CW'(buf_push) - CW'(buf_pop);
            end
        end
    end

    // NOTE: storage arrays are not reset; the counters and pointers alone define which entries are valid.
    always_ff @(posedge i_clk) begin
        if (gnt_acc) pc_mem[pc_wr] <= i_pc_addr;
        if (buf_push) begin
            inst_mem[buf_wr] <= i_mem_rdata;
            ipc_mem[buf_wr]  <= pc_mem[pc_rd];
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus randomized traffic against a queue-based model.
module tb_fetch_ctrl;
    localparam int D = 2;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [31:0] i_pc_addr = '0;
    logic        i_redirect = 1'b0, i_halt = 1'b0, i_mem_gnt = 1'b0;
    logic        i_mem_rvalid = 1'b0, i_dec_ready = 1'b0;
    logic [31:0] i_mem_rdata = '0;
    logic        o_pc_hold, o_mem_req, o_inst_valid, o_busy;
    logic [31:0] o_mem_addr, o_inst, o_inst_pc;

    always #5 i_clk = ~i_clk;

    fetch_ctrl #(.DEPTH(D)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_pc_addr(i_pc_addr), .i_redirect(i_redirect),
        .i_halt(i_halt), .o_pc_hold(o_pc_hold), .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr),
        .i_mem_gnt(i_mem_gnt), .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata),
        .o_inst_valid(o_inst_valid), .o_inst(o_inst), .o_inst_pc(o_inst_pc),
        .i_dec_ready(i_dec_ready), .o_busy(o_busy)
    );

    typedef struct { logic [31:0] inst; logic [31:0] pc; } entry_t;
    typedef struct { logic [31:0] data; int due; } resp_t;

    // Reference model: in-flight bookkeeping, address queue, decode buffer and a simple in-order memory.
    entry_t      bufq[$];
    logic [31:0] pcq[$];
    resp_t       mem_q[$];
    int          m_out, m_drop, cyc, lat_max;
    logic [31:0] pc;
    logic        exp_valid, exp_req, exp_hold, exp_busy, exp_pop, exp_byp, cur_rv;
    logic [31:0] exp_inst, exp_pc;
    logic        c_rst, c_redir, c_gnt;
    int          total, bad;

    task automatic drive(input logic rst, redir, halt, gnt, ready, resp_en);
        int live, credit;
        @(negedge i_clk);
        c_rst = rst; c_redir = redir; c_gnt = gnt;
        cur_rv = resp_en && (mem_q.size() > 0) && (mem_q[0].due <= cyc);
        i_rst = rst; i_redirect = redir; i_halt = halt; i_mem_gnt = gnt;
        i_dec_ready = ready; i_pc_addr = pc;
        i_mem_rvalid = cur_rv;
        i_mem_rdata = cur_rv ? mem_q[0].data : $urandom;
        #1;
        live     = m_out - m_drop;
        exp_pop  = (bufq.size() > 0) && !redir && ready;
        credit   = bufq.size() - int'(exp_pop) + live;
        exp_req  = !rst && !halt && (m_out < D) && (redir || credit < D);
        exp_hold = !(exp_req && gnt);
        exp_busy = (m_out != 0) || (bufq.size() != 0);
        exp_byp  = 1'b0;
`ifdef FETCH_BYPASS_EN
        exp_byp  = cur_rv && (m_out > 0) && (m_drop == 0) && !redir && (bufq.size() == 0) && ready;
`endif
        exp_valid = ((bufq.size() > 0) && !redir) || exp_byp;
        exp_inst  = '0;
        exp_pc    = '0;
        if (exp_byp) begin
            exp_inst = i_mem_rdata;
            exp_pc   = pcq[0];
        end else if (bufq.size() > 0) begin
            exp_inst = bufq[0].inst;
            exp_pc   = bufq[0].pc;
        end
    endtask

    task automatic advance();
        logic   gacc, rv_ok;
        entry_t e;
        resp_t  r;
        gacc = exp_req && c_gnt;
        if (cur_rv) void'(mem_q.pop_front());
        if (c_rst) begin
            m_out = 0; m_drop = 0; pcq.delete(); bufq.delete();
        end else begin
            rv_ok = cur_rv && (m_out > 0);
            if (exp_pop) void'(bufq.pop_front());
            if (c_redir) begin
                m_drop = m_out - int'(rv_ok);
                bufq.delete();
                pcq.delete();
            end else if (rv_ok) begin
                if (m_drop > 0) m_drop--;
                else begin
                    e.pc = pcq.pop_front();
                    e.inst = i_mem_rdata;
                    if (!exp_byp) bufq.push_back(e);
                end
            end
            m_out += int'(gacc) - int'(rv_ok);
            if (gacc) begin
                pcq.push_back(pc);
                r.data = $urandom;
                r.due  = cyc + 1 + int'($urandom_range(lat_max, 0));
                mem_q.push_back(r);
            end
        end
        if (!exp_hold) pc += 32'd4;
        cyc++;
    endtask

    task automatic do_reset();
        drive(1, 0, 0, 0, 0, 0);
        advance();
        mem_q.delete();
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1, 0, 0, 1, 1, 1);
            total++;
            if ({o_mem_req, o_pc_hold} !== 2'b01) begin
                bad++; $display("FAIL reset_req_hold got=%b required=01", {o_mem_req, o_pc_hold});
            end
            advance();
        end
        mem_q.delete();
        drive(0, 0, 1, 0, 0, 0);
        total++;
        if ({o_inst_valid, o_busy, o_mem_req} !== 3'b000) begin
            bad++; $display("FAIL reset_state got v/b/r=%b required=000", {o_inst_valid, o_busy, o_mem_req});
        end
        advance();
    endtask

    task automatic test_stream();
        logic [31:0] seen[$];
        int          when[$];
        do_reset();
        pc = 32'h0; lat_max = 0;
        for (int i = 0; i < 7; i++) begin
            drive(0, 0, 0, 1, 1, 1);
            total++;
            if ({o_inst_valid, o_mem_req, o_pc_hold, o_busy} !== {exp_valid, exp_req, exp_hold, exp_busy}) begin
                bad++; $display("FAIL stream_ctrl cyc=%0d got=%b required=%b", cyc,
                    {o_inst_valid, o_mem_req, o_pc_hold, o_busy}, {exp_valid, exp_req, exp_hold, exp_busy});
            end
            if (exp_valid) begin
                total++;
                if ({o_inst, o_inst_pc} !== {exp_inst, exp_pc}) begin
                    bad++; $display("FAIL stream_data cyc=%0d got=%h/%h required=%h/%h", cyc, o_inst, o_inst_pc, exp_inst, exp_pc);
                end
            end
            total++;
            if (o_pc_hold !== 1'b0) begin
                bad++; $display("FAIL stream_hold cyc=%0d got=%b required=0", cyc, o_pc_hold);
            end
            if (o_inst_valid && i_dec_ready) begin
                seen.push_back(o_inst_pc);
                when.push_back(i);
            end
            advance();
        end
        total++;
        if (seen.size() < 3) begin
            bad++; $display("FAIL stream_count got=%0d required>=3", seen.size());
        end else if (seen[0] !== 32'h0 || seen[1] !== 32'h4 || seen[2] !== 32'h8 || when[2] - when[0] != 2) begin
            bad++; $display("FAIL stream_order got=%h,%h,%h span=%0d required=0,4,8 span=2",
                seen[0], seen[1], seen[2], when[2] - when[0]);
        end
    endtask

    task automatic test_backpressure();
        int grants, pops;
        do_reset();
        pc = 32'h1000; lat_max = 0; grants = 0; pops = 0;
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 0, 1, 0, 1);
            total++;
            if ({o_inst_valid, o_mem_req, o_pc_hold, o_busy} !== {exp_valid, exp_req, exp_hold, exp_busy}) begin
                bad++; $display("FAIL bp_ctrl cyc=%0d got=%b required=%b", cyc,
                    {o_inst_valid, o_mem_req, o_pc_hold, o_busy}, {exp_valid, exp_req, exp_hold, exp_busy});
            end
            if (o_mem_req && i_mem_gnt) grants++;
            advance();
        end
        total++;
        if (grants != 2 || o_mem_req !== 1'b0 || o_pc_hold !== 1'b1) begin
            bad++; $display("FAIL bp_stall got grants=%0d req=%b hold=%b required 2/0/1", grants, o_mem_req, o_pc_hold);
        end
        grants = 0;
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 0, 1, 1, 1);
            total++;
            if ({o_inst_valid, o_mem_req, o_pc_hold, o_busy} !== {exp_valid, exp_req, exp_hold, exp_busy}) begin
                bad++; $display("FAIL bp_release cyc=%0d got=%b required=%b", cyc,
                    {o_inst_valid, o_mem_req, o_pc_hold, o_busy}, {exp_valid, exp_req, exp_hold, exp_busy});
            end
            if (exp_valid) begin
                total++;
                if ({o_inst, o_inst_pc} !== {exp_inst, exp_pc}) begin
                    bad++; $display("FAIL bp_data cyc=%0d got=%h/%h required=%h/%h", cyc, o_inst, o_inst_pc, exp_inst, exp_pc);
                end
            end
            if (o_mem_req && i_mem_gnt) grants++;
            if (o_inst_valid && i_dec_ready) pops++;
            advance();
        end
        total++;
        if (grants != pops || pops != 8) begin
            bad++; $display("FAIL bp_per_pop got grants=%0d pops=%0d required 8/8", grants, pops);
        end
    endtask

    task automatic test_redirect();
        logic        found;
        logic [31:0] got;
        do_reset();
        pc = 32'h2000; lat_max = 0; found = 1'b0; got = '0;
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 0, 1, 0, 0);
            advance();
        end
        pc = 32'h100;
        drive(0, 1, 0, 1, 1, 0);
        total++;
        if ({o_inst_valid, o_mem_req, o_pc_hold, o_busy} !== 4'b0011) begin
            bad++; $display("FAIL redir_cycle got v/r/h/b=%b required=0011", {o_inst_valid, o_mem_req, o_pc_hold, o_busy});
        end
        advance();
        for (int i = 0; i < 20 && !found; i++) begin
            drive(0, 0, 0, 1, 1, 1);
            total++;
            if ({o_inst_valid, o_mem_req, o_pc_hold, o_busy} !== {exp_valid, exp_req, exp_hold, exp_busy}) begin
                bad++; $display("FAIL redir_ctrl cyc=%0d got=%b required=%b", cyc,
                    {o_inst_valid, o_mem_req, o_pc_hold, o_busy}, {exp_valid, exp_req, exp_hold, exp_busy});
            end
            if (o_inst_valid) begin
                found = 1'b1;
                got = o_inst_pc;
            end
            advance();
        end
        total++;
        if (!found || got !== 32'h100) begin
            bad++; $display("FAIL redir_target got found=%b pc=%h required found=1 pc=00000100", found, got);
        end
    endtask

    task automatic test_redirect_resp();
        do_reset();
        pc = 32'h3000; lat_max = 0;
        drive(0, 0, 0, 1, 1, 0);
        advance();
        pc = 32'h200;
        drive(0, 1, 0, 0, 1, 1);
        total++;
        if ({o_inst_valid, o_mem_req, o_pc_hold, o_busy} !== {exp_valid, exp_req, exp_hold, exp_busy}) begin
            bad++; $display("FAIL redir_resp_ctrl got=%b required=%b",
                {o_inst_valid, o_mem_req, o_pc_hold, o_busy}, {exp_valid, exp_req, exp_hold, exp_busy});
        end
        advance();
        drive(0, 0, 1, 0, 1, 0);
        total++;
        if ({o_inst_valid, o_busy} !== 2'b00) begin
            bad++; $display("FAIL redir_resp_after got v/b=%b required=00", {o_inst_valid, o_busy});
        end
        advance();
    endtask

    task automatic test_halt();
        do_reset();
        pc = 32'h4000; lat_max = 0;
        drive(0, 0, 0, 1, 0, 0);
        advance();
        drive(0, 0, 1, 1, 0, 1);
        total++;
        if ({o_mem_req, o_pc_hold, o_busy} !== 3'b011) begin
            bad++; $display("FAIL halt_req got r/h/b=%b required=011", {o_mem_req, o_pc_hold, o_busy});
        end
        advance();
        drive(0, 0, 1, 1, 0, 0);
        total++;
        if (o_inst_valid !== 1'b1 || o_inst_pc !== 32'h4000 || o_inst !== exp_inst) begin
            bad++; $display("FAIL halt_buffered got v=%b pc=%h inst=%h required 1/00004000/%h", o_inst_valid, o_inst_pc, o_inst, exp_inst);
        end
        advance();
        drive(0, 0, 0, 1, 0, 0);
        total++;
        if (o_mem_req !== 1'b1 || o_mem_addr !== 32'h4004 || o_pc_hold !== 1'b0) begin
            bad++; $display("FAIL halt_resume got r=%b addr=%h h=%b required 1/00004004/0", o_mem_req, o_mem_addr, o_pc_hold);
        end
        advance();
    endtask

    task automatic test_reset_mid();
        do_reset();
        pc = 32'h5000; lat_max = 0;
        drive(0, 0, 0, 1, 0, 0);
        advance();
        drive(0, 0, 0, 1, 0, 1);
        advance();
        drive(1, 0, 0, 0, 0, 0);
        total++;
        if ({o_mem_req, o_pc_hold} !== 2'b01) begin
            bad++; $display("FAIL midrst_hold got r/h=%b required=01", {o_mem_req, o_pc_hold});
        end
        advance();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 0, 1, 1);
            total++;
            if ({o_inst_valid, o_busy} !== 2'b00) begin
                bad++; $display("FAIL midrst_late cyc=%0d got v/b=%b required=00", cyc, {o_inst_valid, o_busy});
            end
            advance();
        end
    endtask

    task automatic test_random();
        logic        redir;
        logic [31:0] r;
        do_reset();
        r = $urandom;
        pc = {r[31:2], 2'b00};
        lat_max = 3;
        for (int i = 0; i < 3000; i++) begin
            redir = ($urandom % 16) == 0;
            if (redir) begin
                r = $urandom;
                pc = {r[31:2], 2'b00};
            end
            drive(0, redir, ($urandom % 10) == 0, ($urandom % 4) != 0, ($urandom % 4) != 0, ($urandom % 3) != 0);
            total++;
            if ({o_inst_valid, o_mem_req, o_pc_hold, o_busy} !== {exp_valid, exp_req, exp_hold, exp_busy}) begin
                bad++; $display("FAIL rand_ctrl cyc=%0d got=%b required=%b", cyc,
                    {o_inst_valid, o_mem_req, o_pc_hold, o_busy}, {exp_valid, exp_req, exp_hold, exp_busy});
            end
            if (exp_valid) begin
                total++;
                if ({o_inst, o_inst_pc} !== {exp_inst, exp_pc}) begin
                    bad++; $display("FAIL rand_data cyc=%0d got=%h/%h required=%h/%h", cyc, o_inst, o_inst_pc, exp_inst, exp_pc);
                end
            end
            advance();
        end
    endtask

    initial begin
        total = 0; bad = 0; cyc = 0; lat_max = 0; pc = '0;
        m_out = 0; m_drop = 0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_redirect_resp();
        test_halt();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
